reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width; NREGS = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 raddr1, raddr2  input  ADDR_W  read-port indices.
REQ-007 rdata1, rdata2  output  DATA_W  read-port data.
REQ-008 we, waddr, wdata  input  1/ADDR_W/DATA_W  writeback strobe, index and data.
REQ-009 iss_valid, iss_reg  input  1/ADDR_W  issue of an instruction that will later write iss_reg.
REQ-010 busy1, busy2  output  1  pending-write flag for raddr1/raddr2.
REQ-011 pend_cnt  output  ADDR_W+1  number of registers currently marked busy.

Function
REQ-012 Reads SHALL be combinational from storage: rdataN = reg[raddrN].
REQ-013 At a rising edge with we=1, reg[waddr] SHALL take wdata; with ZERO_REG=1 and waddr=0 the write SHALL be discarded.
REQ-014 With ZERO_REG=1, rdataN SHALL be 0 and busyN SHALL be 0 whenever raddrN=0, regardless of bypass.
REQ-015 Scoreboard: at a rising edge, iss_valid=1 SHALL set busy[iss_reg]; we=1 SHALL clear busy[waddr].
REQ-016 Simultaneous set and clear of the same index SHALL leave it set (newer producer wins).
REQ-017 Set/clear of index 0 with ZERO_REG=1 SHALL be ignored; busy[0] stays 0.
REQ-018 A writeback to a non-busy register SHALL update storage and leave the scoreboard unchanged (no underflow).
REQ-019 Issue to an already-busy register SHALL leave it busy; pend_cnt SHALL not double-count.
REQ-020 pend_cnt SHALL be registered and equal the population count of busy[] after each edge; range 0..NREGS (or NREGS-1 with ZERO_REG=1).
REQ-021 Latency: a write or scoreboard change SHALL be visible on read outputs in the cycle after the edge, unless bypass applies.

Reset
REQ-022 reset=0 SHALL immediately, independent of clk, clear all registers to 0, all busy bits to 0 and pend_cnt to 0.
REQ-023 Reset asserted mid-operation SHALL discard any same-cycle write or issue; first update occurs at the first rising edge after reset=1.

Configuration
REQ-024 Macro REG_FILE_SB_BYPASS_EN SHALL enable write-through bypass.
REQ-025 When defined: if we=1, waddr=raddrN and (raddrN!=0 or ZERO_REG=0), rdataN SHALL be wdata and busyN SHALL be 0 unless iss_valid=1 with iss_reg=raddrN in the same cycle.
REQ-026 When undefined: rdataN and busyN SHALL reflect stored state only; same-cycle writes are seen the next cycle.

Structure
REQ-027 A shared package reg_file_pkg SHALL hold default DATA_W/ADDR_W constants and the data/index typedefs.
REQ-028 The scoreboard (busy bits, pend_cnt) SHALL be a sub-module reg_scoreboard; storage and bypass stay in the top.

Verification
REQ-029 Reset: write 0xDEADBEEF to r5, pulse reset=0 asynchronously -> rdata of r5 = 0, pend_cnt = 0 without a clock edge.
REQ-030 Zero register: we=1, waddr=0, wdata=0xFFFFFFFF; iss_reg=0 -> rdata1(raddr1=0)=0, busy1=0, pend_cnt=0.
REQ-031 Bypass: we=1, waddr=7, wdata=0x12345678, raddr1=7 same cycle -> rdata1=0x12345678 with macro, old value without.
REQ-032 Scoreboard: issue r3, r4, r3 on three edges -> pend_cnt=2; writeback r3 -> busy[3]=0, pend_cnt=1.
REQ-033 Collision: iss_reg=9 and we/waddr=9 same edge with r9 busy -> busy[9] stays 1, pend_cnt unchanged, reg[9]=wdata.
REQ-034 Fill: issue all indices 1..31 -> pend_cnt=31; write back all -> pend_cnt=0, no underflow on extra writeback.

Source files
------------

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and typedefs for the register file with scoreboard
package reg_file_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] idx_t;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write busy bits and registered population count
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_set,
  input  logic [ADDR_W-1:0]      i_set_idx,
  input  logic                   i_clr,
  input  logic [ADDR_W-1:0]      i_clr_idx,
  output logic [(2**ADDR_W)-1:0] o_busy,
  output logic [ADDR_W:0]        o_pend_cnt
);

  logic [(2**ADDR_W)-1:0] r_busy;
  logic [ADDR_W:0]        r_pend_cnt;
  logic [(2**ADDR_W)-1:0] w_busy_nxt;
  logic [ADDR_W:0]        w_cnt_nxt;

  // Clear first, then set, so a same-edge issue to the written index stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr) w_busy_nxt[i_clr_idx] = 1'b0;
    if (i_set) w_busy_nxt[i_set_idx] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_cnt_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_pend_cnt = r_pend_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2R1W register file with issue scoreboard; REG_FILE_SB_BYPASS_EN enables write-through bypass
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_reg,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt
);

  logic [DATA_W-1:0]      r_regs [2**ADDR_W];
  logic [(2**ADDR_W)-1:0] w_busy;
  logic                   w_wr_en;

  assign w_wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set      (iss_valid),
    .i_set_idx  (iss_reg),
    .i_clr      (we),
    .i_clr_idx  (waddr),
    .o_busy     (w_busy),
    .o_pend_cnt (pend_cnt)
  );

  always_comb begin
    rdata1 = r_regs[raddr1];
    busy1  = w_busy[raddr1];
    rdata2 = r_regs[raddr2];
    busy2  = w_busy[raddr2];
`ifdef REG_FILE_SB_BYPASS_EN
    if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
      busy1  = iss_valid && (iss_reg == raddr1);
    end
    if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
      busy2  = iss_valid && (iss_reg == raddr2);
    end
`endif
    // Index 0 wins over any bypass when it is hardwired.
    if ((ZERO_REG != 0) && (raddr1 == '0)) begin
      rdata1 = '0;
      busy1  = 1'b0;
    end
    if ((ZERO_REG != 0) && (raddr2 == '0)) begin
      rdata2 = '0;
      busy2  = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard-queue bench for reg_file_sb (default DATA_W=32, ADDR_W=5, ZERO_REG=1)
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2**AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] raddr1, raddr2, waddr, iss_reg;
  logic [DW-1:0] rdata1, rdata2, wdata;
  logic          we, iss_valid, busy1, busy2;
  logic [AW:0]   pend_cnt;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      0:       return {32'b0, rdata1};
      1:       return {32'b0, rdata2};
      2:       return {63'b0, busy1};
      3:       return {63'b0, busy2};
      default: return {58'b0, pend_cnt};
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = m_regs[a];
`ifdef REG_FILE_SB_BYPASS_EN
    if (we && waddr == a) v = wdata;
`endif
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    logic b;
    b = m_busy[a];
`ifdef REG_FILE_SB_BYPASS_EN
    if (we && waddr == a) b = iss_valid && (iss_reg == a);
`endif
    if (a == 0) b = 1'b0;
    return b;
  endfunction

  function automatic logic [63:0] exp_pend();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
    return 64'(c);
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic flush_checks();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0; iss_valid = 1'b0; iss_reg = '0;
  endtask

  // Advance the model with the current inputs, clock the DUT, sample after the edge.
  task automatic tick();
    if (reset) begin
      if (we && waddr != 0) begin
        m_regs[waddr] = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (iss_valid && iss_reg != 0) m_busy[iss_reg] = 1'b1;
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk_rd(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    raddr1 = a1;
    raddr2 = a2;
    push_exp({tag, ".rdata1"}, 0, {32'b0, exp_rd(a1)});
    push_exp({tag, ".rdata2"}, 1, {32'b0, exp_rd(a2)});
    push_exp({tag, ".busy1"},  2, {63'b0, exp_busy(a1)});
    push_exp({tag, ".busy2"},  3, {63'b0, exp_busy(a2)});
    push_exp({tag, ".pend"},   4, exp_pend());
    #1;
    flush_checks();
  endtask

  task automatic chk_pend(input string tag);
    push_exp(tag, 4, exp_pend());
    #1;
    flush_checks();
  endtask

  initial begin
    reset = 1'b0;
    raddr1 = '0;
    raddr2 = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    chk_rd("rst_state", 5'd5, 5'd31);

    // Async reset clears storage and scoreboard without a clock edge.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; iss_valid = 1'b1; iss_reg = 5'd6;
    tick();
    chk_rd("wr_r5", 5'd5, 5'd6);
    #1 reset = 1'b0;
    model_reset();
    chk_rd("async_rst", 5'd5, 5'd6);
    we = 1'b1; waddr = 5'd5; wdata = 32'h1111_2222; iss_valid = 1'b1; iss_reg = 5'd5;
    tick();
    chk_rd("rst_held", 5'd5, 5'd5);
    #2 reset = 1'b1;

    // Writes and issues to index 0 are discarded.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; iss_valid = 1'b1; iss_reg = 5'd0;
    chk_rd("zero_same", 5'd0, 5'd0);
    tick();
    chk_rd("zero_after", 5'd0, 5'd0);

    // Same-cycle write to a busy register read on both ports.
    we = 1'b1; waddr = 5'd7; wdata = 32'hAAAA5555; iss_valid = 1'b1; iss_reg = 5'd8;
    tick();
    iss_valid = 1'b1; iss_reg = 5'd7;
    tick();
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    chk_rd("bypass", 5'd7, 5'd8);
    tick();
    chk_rd("bypass_after", 5'd7, 5'd8);
    we = 1'b1; waddr = 5'd8; wdata = 32'h0;
    tick();

    // Issue r3, r4, r3 then write back r3.
    iss_valid = 1'b1; iss_reg = 5'd3; tick();
    iss_valid = 1'b1; iss_reg = 5'd4; tick();
    iss_valid = 1'b1; iss_reg = 5'd3; tick();
    chk_rd("sb_issue", 5'd3, 5'd4);
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0333; tick();
    chk_rd("sb_wb", 5'd3, 5'd4);

    // Same-edge issue and writeback of busy r9.
    iss_valid = 1'b1; iss_reg = 5'd9; tick();
    chk_rd("coll_pre", 5'd9, 5'd4);
    we = 1'b1; waddr = 5'd9; wdata = 32'h9999_0009; iss_valid = 1'b1; iss_reg = 5'd9;
    chk_rd("coll_same", 5'd9, 5'd9);
    tick();
    chk_rd("coll_post", 5'd9, 5'd4);

    // Clear leftovers, then fill all non-zero indices and drain them.
    we = 1'b1; waddr = 5'd4; wdata = 32'h4; tick();
    we = 1'b1; waddr = 5'd9; wdata = 32'h9; tick();
    chk_pend("drained");
    for (int i = 1; i < NR; i++) begin
      iss_valid = 1'b1; iss_reg = AW'(i); tick();
    end
    chk_rd("fill_full", 5'd1, 5'd31);
    for (int i = 1; i < NR; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = $urandom; tick();
      chk_pend($sformatf("drain_%0d", i));
    end
    we = 1'b1; waddr = 5'd1; wdata = 32'hCAFE0001; tick();
    chk_rd("extra_wb", 5'd1, 5'd2);
    for (int i = 0; i < 4; i++) begin
      chk_rd($sformatf("rand_rd_%0d", i), AW'($urandom_range(0, NR-1)), AW'($urandom_range(0, NR-1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
